// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Accepts ALU commands, drives a registered operand/select bus to an
//            external combinational ALU and queues {result, carry, tag} in a
//            response FIFO. Optional macro ALU_SEQ_STATS_EN enables op_count.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [3:0]  cmd_tag,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [63:0] alu_out,
    input  logic        alu_carry,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_carry,
    output logic [3:0]  rsp_tag,
    output logic [15:0] op_count
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 64 + 1 + 4;

    localparam logic [0:0]       c_IDLE  = 1'b0;
    localparam logic [0:0]       c_ISSUE = 1'b1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);

    logic [0:0]         r_state;
    logic               r_ready_en;
    logic [3:0]         r_tag;
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_accept;
    logic w_push;
    logic w_pop;

    // r_ready_en keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = r_ready_en && (r_state == c_IDLE) && (r_count < c_DEPTH);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_push    = (r_state == c_ISSUE);
    assign rsp_valid = (r_count != '0);
    assign w_pop     = rsp_valid && rsp_ready;

    // Head is masked when empty so stale storage never shows on the outputs
    assign {rsp_data, rsp_carry, rsp_tag} = rsp_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_ready_en <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            r_tag      <= '0;
        end else begin
            r_ready_en <= 1'b1;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_ISSUE;
                        alu_a   <= cmd_a;
                        alu_b   <= cmd_b;
                        alu_sel <= cmd_op;
                        r_tag   <= cmd_tag;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {alu_out, alu_carry, r_tag};
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_pop && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`else
    assign op_count = '0;
`endif

endmodule

`default_nettype wire
